// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - PRESENT-80 key schedule widths, S-box tables and FSM states
package present_pkg;

  localparam int KEY_W = 80;
  localparam int RK_W  = 64;
  localparam int CNT_W = 5;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/present_key_round.sv
// rtl/present_key_round.sv - one forward or inverse PRESENT-80 key update (combinational)
module present_key_round
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  input  logic [CNT_W-1:0] cnt,
  input  logic             inDir,
  output logic [KEY_W-1:0] outKey
);

  logic [KEY_W-1:0] fwd;
  logic [KEY_W-1:0] inv;

  always_comb begin
    // rotate left 61 == rotate right 19
    fwd          = {key[18:0], key[79:19]};
    fwd[79:76]   = SBOX[fwd[79:76]];
    fwd[19:15]   = fwd[19:15] ^ cnt;

    inv          = key;
    inv[19:15]   = inv[19:15] ^ cnt;
    inv[79:76]   = SBOX_INV[inv[79:76]];
    inv          = {inv[60:0], inv[79:61]};

    outKey       = inDir ? inv : fwd;
  end

endmodule

// File: rtl/present_inv_key_sched.sv
// rtl/present_inv_key_sched.sv - inverse PRESENT-80 key schedule, K(ROUNDS+1) down to K1
// Optional integrity check of the unwound key: PRESENT_INVKEY_CHECK_EN
module present_inv_key_sched
  import present_pkg::*;
#(
  parameter int ROUNDS = 31
) (
  input  logic             inClk,
  input  logic             inRst,
  input  logic             inKeyWr,
  input  logic [KEY_W-1:0] inKeyData,
  input  logic             inKeyNext,
  output logic             outBusy,
  output logic             outKeyValid,
  output logic [RK_W-1:0]  outRoundKey,
  output logic [5:0]       outRoundIdx,
  output logic             outDone,
  output logic             outKeyErr
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS);

  state_t           state_q, state_n;
  logic [KEY_W-1:0] key_q, key_n, key_rnd;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             done_n;

  present_key_round u_round (
    .key    (key_q),
    .cnt    (cnt_q),
    .inDir  (state_q == OUT),
    .outKey (key_rnd)
  );

  always_comb begin
    state_n = state_q;
    key_n   = key_q;
    cnt_n   = cnt_q;
    done_n  = 1'b0;
    if (inKeyWr) begin
      state_n = FWD;
      key_n   = inKeyData;
      cnt_n   = 5'd1;
    end else begin
      case (state_q)
        FWD: begin
          key_n = key_rnd;
          if (cnt_q == LAST_CNT) state_n = OUT;
          else                   cnt_n   = cnt_q + 5'd1;
        end
        OUT: begin
          if (inKeyNext) begin
            // counter 0 means K1 is on the output
            if (cnt_q == 5'd0) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              key_n = key_rnd;
              cnt_n = cnt_q - 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // outputs are registered from the next-state values so they line up with the state
  always_ff @(posedge inClk) begin
    if (inRst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      cnt_q       <= '0;
      outBusy     <= 1'b0;
      outKeyValid <= 1'b0;
      outRoundKey <= '0;
      outRoundIdx <= '0;
      outDone     <= 1'b0;
    end else begin
      state_q     <= state_n;
      key_q       <= key_n;
      cnt_q       <= cnt_n;
      outBusy     <= (state_n == FWD);
      outKeyValid <= (state_n == OUT);
      outRoundKey <= key_n[KEY_W-1:16];
      outRoundIdx <= (state_n == OUT) ? ({1'b0, cnt_n} + 6'd1) : 6'd0;
      outDone     <= done_n;
    end
  end

`ifdef PRESENT_INVKEY_CHECK_EN
  logic [KEY_W-1:0] copy_q;
  logic             err_q, err_n;

  always_comb begin
    err_n = err_q;
    if (inKeyWr)
      err_n = 1'b0;
    else if (state_q == OUT && inKeyNext && cnt_q == 5'd1 && key_rnd != copy_q)
      err_n = 1'b1;
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      copy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (inKeyWr) copy_q <= inKeyData;
      err_q <= err_n;
    end
  end

  assign outKeyErr = err_q;
`else
  assign outKeyErr = 1'b0;
`endif

endmodule

// File: doc/present_inv_key_sched.md
Name: present_inv_key_sched

Overview:
Inverse PRESENT-80 key schedule for the decryption datapath. Loads the 80-bit user key and runs the forward key update 31 times to reach the last-round state. It then presents round keys K32 down to K1, one per consumer request, by applying the inverse key update. It sits beside the key register and feeds the decryption round logic.

Parameters:
ROUNDS, 31, number of forward key updates; K(ROUNDS+1) is the first key output. Legal range 1..31, because the counter is XORed as 5 bits.

Ports:
inClk  input  1  clock, all logic on rising edge
inRst  input  1  synchronous reset, active-high
inKeyWr  input  1  load strobe; samples inKeyData and (re)starts the schedule
inKeyData  input  80  user key
inKeyNext  input  1  consumer done with current round key; advance to the previous round
outBusy  output  1  high while the forward pass runs
outKeyValid  output  1  outRoundKey/outRoundIdx are valid
outRoundKey  output  64  current round key = key state [79:16]
outRoundIdx  output  6  round number of outRoundKey, ROUNDS+1 down to 1; 0 when not valid
outDone  output  1  one-cycle pulse after K1 is consumed
outKeyErr  output  1  integrity error flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock, inClk. Reset is synchronous and active-high on inRst.
- Reset: state IDLE, key state 80'b0, counter 0, and every output 0.
- Forward update with counter c:
  - rotate left 61;
  - [79:76] = S([79:76]);
  - [19:15] ^= c[4:0].
- Inverse update with counter c, applied in this order:
  - [19:15] ^= c[4:0];
  - [79:76] = S^-1([79:76]);
  - rotate right 61.
- IDLE:
  - outKeyValid=0, outBusy=0.
  - inKeyWr=1: key state <= inKeyData, counter <= 1, go to FWD.
- FWD:
  - outBusy=1, outKeyValid=0.
  - Each cycle: apply forward update with counter, then counter++.
  - When the update with counter==ROUNDS executes, go to OUT with counter=ROUNDS.
  - outKeyValid rises ROUNDS edges after the loading edge (31 by default).
- OUT:
  - outKeyValid=1, outRoundIdx=counter+1, outRoundKey=state[79:16].
  - inKeyNext=1 and outRoundIdx>1: apply inverse update with counter, then counter--. The new key appears the next cycle.
  - inKeyNext=1 and outRoundIdx==1: go to IDLE. outDone=1 for exactly that next cycle, and outKeyValid drops with it.
  - inKeyNext held high steps one round per cycle.
- inKeyNext outside OUT: ignored.
- inKeyWr in FWD or OUT: aborts and restarts as from IDLE. outKeyValid is 0 the next cycle.
- inKeyWr and inKeyNext in the same cycle: inKeyWr wins.
- inRst mid-operation: immediate return to reset state. A restart needs a new inKeyWr.
- All outputs are registered. No combinational path from any input to any output.

Optional Feature:
Macro: PRESENT_INVKEY_CHECK_EN.
- Defined:
  - An 80-bit copy of the original key is captured on inKeyWr.
  - When the state reaches outRoundIdx==1, the full 80-bit key state is compared with the copy.
  - Mismatch sets outKeyErr on the same edge outRoundIdx becomes 1.
  - outKeyErr is sticky until the next inKeyWr or inRst.
- Undefined: no copy register is built, and outKeyErr is tied to 0.

Decomposition:
- Package present_pkg holds:
  - KEY_W=80, RK_W=64, CNT_W=5;
  - 4-bit S-box and inverse S-box constant arrays;
  - state enum IDLE/FWD/OUT.
- One natural sub-module: present_key_round. It is combinational, with inputs key[79:0], cnt[4:0] and inDir (0=forward, 1=inverse), and output next key. It is shareable with the encryption key path.

Test Plan:
1. inRst high for 2 cycles -> all outputs 0, outRoundIdx=0. Then inKeyNext pulses -> no change.
2. Load key 80'h0 -> outBusy high for 31 cycles, then outKeyValid=1 with outRoundIdx=32, and K32 matches the software model. Step with inKeyNext:
   - idx 2 key = 64'hC000000000000000;
   - idx 1 key = 64'h0;
   - the next inKeyNext gives one outDone pulse, outKeyValid=0, outKeyErr=0.
3. Load key 80'hFFFF_FFFFFFFF_FFFFFFFF with inKeyNext held high throughout -> no effect during FWD. Then one round per cycle from 32 to 1, ending with idx 1 key = 64'hFFFFFFFFFFFFFFFF.
4. At idx 20, assert inKeyWr together with inKeyNext and a new key 80'h0123456789ABCDEF0123 -> restart: outKeyValid=0 next cycle, 31 busy cycles, then idx 32 with the model's K32 for the new key.
5. inRst asserted mid-FWD (cycle 10) and mid-OUT (idx 15) -> reset state on the next edge, with no outDone.
6. With PRESENT_INVKEY_CHECK_EN, normal runs (random keys ×100) give outKeyErr=0. Forcing one key-state bit flip at idx 16 gives outKeyErr=1 at idx 1, and it stays set until the next inKeyWr.
